// File: rtl/coprocessor0_interrupt_unit_pkg.sv
// coprocessor0_interrupt_unit_pkg: shared CP0 types, register numbers and word-packing helpers.
package coprocessor0_interrupt_unit_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_t;

    typedef struct packed {
        logic [7:0] im;
        logic       exl;
        logic       ie;
    } status_data_t;

    typedef struct packed {
        logic       bd;
        logic       ti;
        logic [7:0] ip;
        exc_code_t  exc_code;
    } cause_data_t;

    typedef struct packed {
        logic        valid;
        logic        eret;
        exc_code_t   code;
        logic [31:0] address;
        logic        delay_slot;
        logic        bad_valid;
        logic [31:0] bad_address;
    } wb_to_cp0_data_t;

    // BEV (bit 22) is hardwired to 1; everything not stored reads 0.
    function automatic logic [31:0] status_word(status_data_t s);
        return {9'd0, 1'b1, 6'd0, s.im, 6'd0, s.exl, s.ie};
    endfunction

    function automatic logic [31:0] cause_word(cause_data_t c);
        return {c.bd, c.ti, 14'd0, c.ip, 1'b0, c.exc_code, 2'd0};
    endfunction

endpackage

// File: rtl/coprocessor0_interrupt_unit_timer.sv
// coprocessor0_interrupt_unit_timer: prescaled Count, Compare and the sticky timer interrupt.
module coprocessor0_interrupt_unit_timer #(
    parameter int COUNT_DIVIDE = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        count_write,
    input  logic        compare_write,
    input  logic [31:0] write_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_interrupt
);

    localparam int PW = COUNT_DIVIDE > 1 ? $clog2(COUNT_DIVIDE) : 1;
    localparam logic [PW-1:0] LAST = PW'(COUNT_DIVIDE - 1);

    logic [PW-1:0] prescale;
    logic          tick;
    logic [31:0]   count_next;

    assign tick       = prescale == LAST;
    assign count_next = count_write ? write_data : count + 32'(tick);

    // TI fires only when Count actually changes onto Compare; a Compare write always clears it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescale        <= '0;
            count           <= '0;
            compare         <= '0;
            timer_interrupt <= 1'b0;
        end else begin
            prescale        <= (count_write || tick) ? '0 : prescale + 1'b1;
            count           <= count_next;
            compare         <= compare_write ? write_data : compare;
            timer_interrupt <= !compare_write &&
                               (timer_interrupt || ((count_write || tick) && count_next == compare));
        end
    end

endmodule

// File: rtl/coprocessor0_interrupt_unit.sv
// coprocessor0_interrupt_unit: CP0 Status/Cause/EPC/BadVAddr, timer and interrupt request.
module coprocessor0_interrupt_unit
    import coprocessor0_interrupt_unit_pkg::*;
#(
    parameter int HW_INT_COUNT = 6,
    parameter int SYNC_STAGES  = 2,
    parameter int COUNT_DIVIDE = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    write_enabled,
    input  logic [4:0]              address_register,
    input  logic [2:0]              address_select,
    input  logic [31:0]             write_data,
    input  logic                    exception_valid,
    input  logic                    eret_flush,
    input  logic [4:0]              exception_code,
    input  logic [31:0]             exception_address,
    input  logic                    in_delay_slot,
    input  logic                    bad_address_valid,
    input  logic [31:0]             bad_address,
    input  logic [HW_INT_COUNT-1:0] hardware_interrupt,
    output logic [31:0]             read_data,
    output logic [31:0]             epc,
    output logic                    interrupt_pending,
    output logic                    timer_interrupt
);

    wb_to_cp0_data_t         wb;
    status_data_t            status;
    cause_data_t             cause_view;
    logic                    cause_bd;
    exc_code_t               cause_exc;
    logic [1:0]              ip_sw;
    logic [31:0]             bad_vaddr;
    logic [31:0]             count;
    logic [31:0]             compare;
    logic [HW_INT_COUNT-1:0] sync_q [SYNC_STAGES+1];
    logic [5:0]              hw_ip;
    logic [7:0]              ip;
    logic                    mtc0;
    logic                    wr_count;
    logic                    wr_compare;
    logic                    wr_status;
    logic                    wr_cause;
    logic                    wr_epc;

    assign wb = '{
        valid:       exception_valid,
        eret:        eret_flush,
        code:        exc_code_t'(exception_code),
        address:     exception_address,
        delay_slot:  in_delay_slot,
        bad_valid:   bad_address_valid,
        bad_address: bad_address
    };

    // A committing exception squashes any MTC0 in the same cycle.
    assign mtc0       = write_enabled && !wb.valid && address_select == 3'd0;
    assign wr_count   = mtc0 && address_register == REG_COUNT;
    assign wr_compare = mtc0 && address_register == REG_COMPARE;
    assign wr_status  = mtc0 && address_register == REG_STATUS;
    assign wr_cause   = mtc0 && address_register == REG_CAUSE;
    assign wr_epc     = mtc0 && address_register == REG_EPC;

    coprocessor0_interrupt_unit_timer #(
        .COUNT_DIVIDE(COUNT_DIVIDE)
    ) u_timer (
        .clock          (clock),
        .reset_n        (reset_n),
        .count_write    (wr_count),
        .compare_write  (wr_compare),
        .write_data     (write_data),
        .count          (count),
        .compare        (compare),
        .timer_interrupt(timer_interrupt)
    );

    // Stage 0 samples the pins; the last stage feeds IP, giving SYNC_STAGES+1 edges of latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= hardware_interrupt;
            for (int i = 1; i <= SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign hw_ip             = 6'(sync_q[SYNC_STAGES]);
    assign ip                = {hw_ip[5] | timer_interrupt, hw_ip[4:0], ip_sw};
    assign interrupt_pending = status.ie && !status.exl && |(status.im & ip);
    assign cause_view        = '{bd: cause_bd, ti: timer_interrupt, ip: ip, exc_code: cause_exc};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            status    <= '0;
            cause_bd  <= 1'b0;
            cause_exc <= EXC_INT;
            ip_sw     <= '0;
            epc       <= '0;
            bad_vaddr <= '0;
        end else if (wb.valid) begin
            status.exl <= 1'b1;
            cause_exc  <= wb.code;
            if (!status.exl) begin
                cause_bd <= wb.delay_slot;
                epc      <= wb.delay_slot ? wb.address - 32'd4 : wb.address;
            end
            if (wb.bad_valid) bad_vaddr <= wb.bad_address;
        end else begin
            if (wr_status) begin
                status.im <= write_data[15:8];
                status.ie <= write_data[0];
            end
            if (wb.eret) status.exl <= 1'b0;
            else if (wr_status) status.exl <= write_data[1];
            if (wr_cause) ip_sw <= write_data[9:8];
            if (wr_epc) epc <= write_data;
        end
    end

    always_comb begin
        read_data = '0;
        if (address_select == 3'd0) begin
            case (address_register)
                REG_BADVADDR: read_data = bad_vaddr;
                REG_COUNT:    read_data = count;
                REG_COMPARE:  read_data = compare;
                REG_STATUS:   read_data = status_word(status);
                REG_CAUSE:    read_data = cause_word(cause_view);
                REG_EPC:      read_data = epc;
                default:      read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_coprocessor0_interrupt_unit.sv
// tb_coprocessor0_interrupt_unit: directed spec scenarios plus randomized traffic against a behavioural CP0 model.
module tb_coprocessor0_interrupt_unit;

    localparam int HW = 6;
    localparam int SYNC = 2;
    localparam int DIV = 2;

    logic          clock;
    logic          reset_n;
    logic          write_enabled;
    logic [4:0]    address_register;
    logic [2:0]    address_select;
    logic [31:0]   write_data;
    logic          exception_valid;
    logic          eret_flush;
    logic [4:0]    exception_code;
    logic [31:0]   exception_address;
    logic          in_delay_slot;
    logic          bad_address_valid;
    logic [31:0]   bad_address;
    logic [HW-1:0] hardware_interrupt;
    logic [31:0]   read_data;
    logic [31:0]   epc;
    logic          interrupt_pending;
    logic          timer_interrupt;

    int n_checks = 0;
    int n_errors = 0;

    coprocessor0_interrupt_unit #(
        .HW_INT_COUNT(HW),
        .SYNC_STAGES (SYNC),
        .COUNT_DIVIDE(DIV)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .write_enabled     (write_enabled),
        .address_register  (address_register),
        .address_select    (address_select),
        .write_data        (write_data),
        .exception_valid   (exception_valid),
        .eret_flush        (eret_flush),
        .exception_code    (exception_code),
        .exception_address (exception_address),
        .in_delay_slot     (in_delay_slot),
        .bad_address_valid (bad_address_valid),
        .bad_address       (bad_address),
        .hardware_interrupt(hardware_interrupt),
        .read_data         (read_data),
        .epc               (epc),
        .interrupt_pending (interrupt_pending),
        .timer_interrupt   (timer_interrupt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: Count is derived from the last loaded value and elapsed cycles,
    // and the synchroniser is a plain history of sampled pin values.
    logic [31:0] m_base, m_compare, m_epc, m_bad;
    longint      m_cyc;
    bit          m_ti, m_exl, m_ie, m_bd;
    logic [7:0]  m_im;
    logic [4:0]  m_exc;
    logic [1:0]  m_sw;
    logic [5:0]  m_hist[$];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_count();
        return m_base + 32'(m_cyc / DIV);
    endfunction

    function automatic logic [7:0] m_ip();
        logic [5:0] h;
        h = (m_hist.size() > SYNC) ? m_hist[SYNC] : 6'd0;
        return {h[5] | m_ti, h[4:0], m_sw};
    endfunction

    function automatic bit m_pending();
        return m_ie && !m_exl && ((m_im & m_ip()) != 8'd0);
    endfunction

    function automatic logic [31:0] exp_read(logic [4:0] a, logic [2:0] s);
        if (s != 3'd0) return 32'd0;
        case (a)
            5'd8:  return m_bad;
            5'd9:  return m_count();
            5'd11: return m_compare;
            5'd12: return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
            5'd13: return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_exc) << 2);
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_base = 0; m_cyc = 0; m_compare = 0; m_epc = 0; m_bad = 0;
        m_ti = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_im = 0; m_exc = 0; m_sw = 0;
        m_hist.delete();
    endtask

    task automatic model_edge();
        logic [31:0] old_c, new_c;
        bit wr, ldc;
        wr = write_enabled && !exception_valid && address_select == 3'd0;
        ldc = wr && address_register == 5'd9;
        old_c = m_count();
        if (ldc) begin
            m_base = write_data;
            m_cyc = 0;
        end else m_cyc++;
        new_c = m_count();
        if (wr && address_register == 5'd11) begin
            m_ti = 0;
            m_compare = write_data;
        end else if ((ldc || new_c != old_c) && new_c == m_compare) m_ti = 1;
        m_hist.push_front(6'(hardware_interrupt));
        if (m_hist.size() > SYNC + 1) void'(m_hist.pop_back());
        if (exception_valid) begin
            if (!m_exl) begin
                m_bd = in_delay_slot;
                m_epc = in_delay_slot ? exception_address - 4 : exception_address;
            end
            m_exl = 1;
            m_exc = exception_code;
            if (bad_address_valid) m_bad = bad_address;
        end else begin
            if (eret_flush) m_exl = 0;
            if (wr && address_register == 5'd12) begin
                m_im = write_data[15:8];
                m_ie = write_data[0];
                if (!eret_flush) m_exl = write_data[1];
            end
            if (wr && address_register == 5'd13) m_sw = write_data[9:8];
            if (wr && address_register == 5'd14) m_epc = write_data;
        end
    endtask

    task automatic idle();
        write_enabled = 0; address_select = 0; write_data = 0;
        exception_valid = 0; eret_flush = 0; exception_code = 0; exception_address = 0;
        in_delay_slot = 0; bad_address_valid = 0; bad_address = 0;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic mtc0(logic [4:0] r, logic [31:0] d);
        write_enabled = 1; address_register = r; address_select = 0; write_data = d;
        cycle();
    endtask

    task automatic read_check(string tag, logic [4:0] r, logic [31:0] exp);
        address_register = r;
        address_select = 0;
        #1;
        check(tag, read_data, exp);
    endtask

    task automatic exception(logic [4:0] code, logic [31:0] addr, bit ds, bit bav, logic [31:0] bad);
        exception_valid = 1; exception_code = code; exception_address = addr;
        in_delay_slot = ds; bad_address_valid = bav; bad_address = bad;
    endtask

    task automatic rand_drive();
        logic [4:0] regs[7];
        logic [4:0] codes[7];
        regs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
        codes = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
        if ($urandom_range(0, 3) == 0) begin
            write_enabled = 1;
            address_register = regs[$urandom_range(0, 6)];
            address_select = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            write_data = $urandom;
            if (address_register == 5'd9 && $urandom_range(0, 1) == 0)
                write_data = m_compare - 32'($urandom_range(0, 3));
            if (address_register == 5'd11 && $urandom_range(0, 1) == 0)
                write_data = m_count() + 32'($urandom_range(0, 6));
        end
        if ($urandom_range(0, 11) == 0)
            exception(codes[$urandom_range(0, 6)], $urandom, 1'($urandom), 1'($urandom), $urandom);
        if ($urandom_range(0, 11) == 0) eret_flush = 1;
        if ($urandom_range(0, 7) == 0) hardware_interrupt = 6'($urandom);
    endtask

    initial begin
        logic [4:0] a;
        logic [2:0] s;
        idle();
        address_register = 0;
        hardware_interrupt = 0;
        reset_n = 0;
        model_reset();
        repeat (3) @(posedge clock);
        #2 reset_n = 1;

        read_check("reset_status", 5'd12, 32'h0040_0000);
        read_check("reset_cause", 5'd13, 32'h0);
        check("reset_pending", 32'(interrupt_pending), 32'd0);
        check("reset_ti", 32'(timer_interrupt), 32'd0);
        check("reset_epc", epc, 32'd0);

        mtc0(5'd9, 32'h10);
        repeat (10) cycle();
        read_check("count_run", 5'd9, 32'h15);
        mtc0(5'd9, 32'hFFFF_FFFF);
        cycle();
        read_check("count_max", 5'd9, 32'hFFFF_FFFF);
        cycle();
        read_check("count_wrap", 5'd9, 32'h0);
        check("wrap_ti_model", 32'(timer_interrupt), 32'(m_ti));

        mtc0(5'd11, 32'h20);
        check("compare_clr_ti", 32'(timer_interrupt), 32'd0);
        mtc0(5'd9, 32'h1E);
        mtc0(5'd12, 32'h0000_8001);
        repeat (2) cycle();
        check("ti_before", 32'(timer_interrupt), 32'd0);
        read_check("count_1f", 5'd9, 32'h1F);
        cycle();
        check("ti_set", 32'(timer_interrupt), 32'd1);
        check("ti_pending", 32'(interrupt_pending), 32'd1);
        read_check("ti_cause", 5'd13, 32'h4000_8000);
        read_check("count_20", 5'd9, 32'h20);
        mtc0(5'd11, 32'h100);
        check("ti_cleared", 32'(timer_interrupt), 32'd0);
        check("ti_clr_pending", 32'(interrupt_pending), 32'd0);

        exception(5'd4, 32'hBFC0_0104, 1, 1, 32'h1235);
        cycle();
        check("exc_epc", epc, 32'hBFC0_0100);
        read_check("exc_epc_rd", 5'd14, 32'hBFC0_0100);
        read_check("exc_cause", 5'd13, 32'h8000_0010);
        read_check("exc_badvaddr", 5'd8, 32'h1235);
        cycle();
        read_check("exc_status", 5'd12, 32'h0040_8003);
        exception(5'd12, 32'h8000_0000, 0, 0, 32'hDEAD);
        cycle();
        check("exc2_epc", epc, 32'hBFC0_0100);
        read_check("exc2_cause", 5'd13, 32'h8000_0030);
        read_check("exc2_badvaddr", 5'd8, 32'h1235);

        eret_flush = 1;
        cycle();
        read_check("eret_status", 5'd12, 32'h0040_8001);
        exception(5'd8, 32'h200, 0, 0, 32'h0);
        write_enabled = 1; address_register = 5'd12; write_data = 32'h0;
        cycle();
        read_check("exc_mtc0_status", 5'd12, 32'h0040_8003);
        check("exc_mtc0_epc", epc, 32'h200);
        read_check("exc_mtc0_cause", 5'd13, 32'h20);
        eret_flush = 1;
        cycle();
        read_check("eret2_status", 5'd12, 32'h0040_8001);

        mtc0(5'd12, 32'h0000_0801);
        hardware_interrupt = 6'b000010;
        repeat (2) cycle();
        read_check("hw_early_cause", 5'd13, 32'h20);
        check("hw_early_pending", 32'(interrupt_pending), 32'd0);
        cycle();
        read_check("hw_cause", 5'd13, 32'h820);
        check("hw_pending", 32'(interrupt_pending), 32'd1);
        hardware_interrupt = 0;
        repeat (2) cycle();
        check("hw_hold_pending", 32'(interrupt_pending), 32'd1);
        cycle();
        read_check("hw_drop_cause", 5'd13, 32'h20);
        check("hw_drop_pending", 32'(interrupt_pending), 32'd0);

        for (int i = 0; i < 600; i++) begin
            rand_drive();
            cycle();
            a = 5'($urandom_range(7, 15));
            s = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd0;
            address_register = a;
            address_select = s;
            #1;
            check($sformatf("rand_read_r%0d_s%0d", a, s), read_data, exp_read(a, s));
            check("rand_pending", 32'(interrupt_pending), 32'(m_pending()));
            check("rand_ti", 32'(timer_interrupt), 32'(m_ti));
            check("rand_epc", epc, m_epc);
        end

        hardware_interrupt = 0;
        repeat (4) cycle();
        mtc0(5'd12, 32'h0000_0003);
        mtc0(5'd9, 32'h1234_0000);
        repeat (5) cycle();
        #2 reset_n = 0;
        model_reset();
        read_check("rst_count", 5'd9, 32'h0);
        read_check("rst_status", 5'd12, 32'h0040_0000);
        read_check("rst_cause", 5'd13, 32'h0);
        check("rst_epc", epc, 32'h0);
        check("rst_ti", 32'(timer_interrupt), 32'd0);
        check("rst_pending", 32'(interrupt_pending), 32'd0);
        @(negedge clock);
        reset_n = 1;
        repeat (4) cycle();
        read_check("post_rst_count", 5'd9, m_count());
        read_check("post_rst_count_val", 5'd9, 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
